// File: rtl/dmem_responder_pkg.sv
// dmem_responder_pkg: shared widths, core run-state encoding and host FSM state codes
package dmem_responder_pkg;
    localparam int DMEM_DATA_W = 16;
    localparam int DMEM_ADDR_W = 8;
    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_EXEC = 1'b1;
    typedef enum logic [1:0] {
        H_IDLE   = 2'd0,
        H_WAIT   = 2'd1,
        H_ACCESS = 2'd2,
        H_ACK    = 2'd3
    } h_state_t;
endpackage

// File: rtl/dmem_array.sv
// dmem_array: DEPTH x DATA_W storage, one sync write port, two async read ports
// ports: clock; we/waddr/wdata write port; raddr_a/rdata_a (CPU) and raddr_b/rdata_b (host) reads
module dmem_array #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
) (
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_b
);
    logic [DATA_W-1:0] mem [2**ADDR_W];
    always_ff @(posedge clock) if (we) mem[waddr] <= wdata;
    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: MEM-stage data memory with post-reset clear sweep and req/ack host port
// ports: clock/reset; state (core run state); CPU d_addr/d_dataout/d_we -> d_datain;
//        host h_req/h_we/h_addr/h_wdata -> h_rdata/h_ack; init_done after clear sweep
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DATA_W = DMEM_DATA_W,
    parameter int ADDR_W = DMEM_ADDR_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              state,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_dataout,
    input  logic              d_we,
    output logic [DATA_W-1:0] d_datain,
    input  logic              h_req,
    input  logic              h_we,
    input  logic [ADDR_W-1:0] h_addr,
    input  logic [DATA_W-1:0] h_wdata,
    output logic [DATA_W-1:0] h_rdata,
    output logic              h_ack,
    output logic              init_done
);
    logic [ADDR_W-1:0] clear_cnt_q, clear_cnt_d;
    logic              init_done_q, init_done_d;
    h_state_t          hs_q, hs_d;
    logic              h_we_q, h_we_d;
    logic [ADDR_W-1:0] h_addr_q, h_addr_d;
    logic [DATA_W-1:0] h_wdata_q, h_wdata_d;
    logic [DATA_W-1:0] h_rdata_q, h_rdata_d;
    logic              host_access;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata, cpu_rdata, host_rdata;

    always_ff @(posedge clock) begin
        if (reset) begin
            clear_cnt_q <= '0;
            init_done_q <= 1'b0;
            hs_q        <= H_IDLE;
            h_we_q      <= 1'b0;
            h_addr_q    <= '0;
            h_wdata_q   <= '0;
            h_rdata_q   <= '0;
        end else begin
            clear_cnt_q <= clear_cnt_d;
            init_done_q <= init_done_d;
            hs_q        <= hs_d;
            h_we_q      <= h_we_d;
            h_addr_q    <= h_addr_d;
            h_wdata_q   <= h_wdata_d;
            h_rdata_q   <= h_rdata_d;
        end
    end

    always_comb begin
        clear_cnt_d = init_done_q ? clear_cnt_q : clear_cnt_q + ADDR_W'(1);
        init_done_d = init_done_q | (clear_cnt_q == '1);
    end

    always_comb begin
        hs_d = hs_q == H_IDLE   ? (h_req ? H_WAIT : H_IDLE) :
               hs_q == H_WAIT   ? ((init_done_q && state != ST_EXEC) ? H_ACCESS : H_WAIT) :
               hs_q == H_ACCESS ? H_ACK : H_IDLE;
        h_we_d    = (hs_q == H_IDLE && h_req) ? h_we    : h_we_q;
        h_addr_d  = (hs_q == H_IDLE && h_req) ? h_addr  : h_addr_q;
        h_wdata_d = (hs_q == H_IDLE && h_req) ? h_wdata : h_wdata_q;
    end

    // Port priority: sweep, then host (even if exec just began), then CPU.
    // Nothing commits on a reset edge so an in-flight host op is truly aborted.
    always_comb begin
        host_access = hs_q == H_ACCESS;
        h_ack       = hs_q == H_ACK;
        mem_we      = !reset && (!init_done_q || (host_access ? h_we_q : (d_we && state == ST_EXEC)));
        mem_waddr   = !init_done_q ? clear_cnt_q : host_access ? h_addr_q : d_addr;
        mem_wdata   = !init_done_q ? '0 : host_access ? h_wdata_q : d_dataout;
        h_rdata_d   = (host_access && !h_we_q) ? host_rdata : h_rdata_q;
    end

    dmem_array #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_array (
        .clock   (clock),
        .we      (mem_we),
        .waddr   (mem_waddr),
        .wdata   (mem_wdata),
        .raddr_a (d_addr),
        .rdata_a (cpu_rdata),
        .raddr_b (h_addr_q),
        .rdata_b (host_rdata)
    );

    assign d_datain  = init_done_q ? cpu_rdata : '0;
    assign h_rdata   = h_rdata_q;
    assign init_done = init_done_q;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed plus randomized checks of dmem_responder against an array model
module tb_dmem_responder;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        state = 1'b0;
    logic [7:0]  d_addr = '0;
    logic [15:0] d_dataout = '0;
    logic        d_we = 1'b0;
    logic [15:0] d_datain;
    logic        h_req = 1'b0;
    logic        h_we = 1'b0;
    logic [7:0]  h_addr = '0;
    logic [15:0] h_wdata = '0;
    logic [15:0] h_rdata;
    logic        h_ack;
    logic        init_done;

    logic [15:0] model [256];
    logic [15:0] last_rd;
    int vectors = 0;
    int miscompares = 0;

    dmem_responder dut (
        .clock(clock), .reset(reset), .state(state),
        .d_addr(d_addr), .d_dataout(d_dataout), .d_we(d_we), .d_datain(d_datain),
        .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
        .h_rdata(h_rdata), .h_ack(h_ack), .init_done(init_done)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic host_op(input logic we, input logic [7:0] a, input logic [15:0] wd,
                           output logic [15:0] rd, output int lat);
        h_req = 1'b1; h_we = we; h_addr = a; h_wdata = wd;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!h_ack && lat < 50);
        chk("host_ack_seen", 32'(h_ack), 32'd1);
        rd = h_rdata;
        h_req = 1'b0;
        tick();
        chk("host_ack_pulse", 32'(h_ack), 32'd0);
    endtask

    task automatic sweep_wait(output int n, output logic ack_seen);
        n = 0;
        ack_seen = 1'b0;
        while (!init_done && n < 300) begin
            tick();
            n++;
            ack_seen |= h_ack;
        end
    endtask

    initial begin
        logic [15:0] rd;
        int lat;
        int n;
        logic ack_seen;
        logic [7:0] a;
        logic [15:0] dt;

        tick();
        tick();
        chk("rst_init_done", 32'(init_done), 32'd0);
        chk("rst_h_ack", 32'(h_ack), 32'd0);
        chk("rst_h_rdata", 32'(h_rdata), 32'd0);
        chk("rst_d_datain", 32'(d_datain), 32'd0);
        reset = 1'b0;
        sweep_wait(n, ack_seen);
        chk("sweep_cycles", 32'(n), 32'd256);
        for (int i = 0; i < 256; i++) model[i] = '0;

        host_op(1'b0, 8'h7F, 16'h0, rd, lat);
        chk("host_rd_7f", 32'(rd), 32'h0000);
        chk("host_latency", 32'(lat), 32'd3);
        last_rd = rd;

        state = 1'b1; d_we = 1'b1; d_addr = 8'h10; d_dataout = 16'hBEEF;
        #1;
        chk("cpu_wr_same_cycle", 32'(d_datain), 32'h0000);
        tick();
        chk("cpu_wr_next_cycle", 32'(d_datain), 32'hBEEF);
        model[8'h10] = 16'hBEEF;
        state = 1'b0; d_dataout = 16'h5555;
        tick();
        d_we = 1'b0;
        host_op(1'b0, 8'h10, 16'h0, rd, lat);
        chk("idle_wr_ignored", 32'(rd), 32'hBEEF);
        last_rd = rd;

        state = 1'b1;
        h_req = 1'b1; h_we = 1'b1; h_addr = 8'h22; h_wdata = 16'h1234;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("no_ack_in_exec", 32'(h_ack), 32'd0);
        end
        state = 1'b0;
        lat = 0;
        while (!h_ack && lat < 50) begin
            tick();
            lat++;
        end
        chk("ack_after_exec", 32'(lat >= 2 && lat <= 3), 32'd1);
        h_req = 1'b0;
        tick();
        chk("ack_after_exec_pulse", 32'(h_ack), 32'd0);
        model[8'h22] = 16'h1234;
        d_addr = 8'h22;
        #1;
        chk("cpu_rd_22", 32'(d_datain), 32'h1234);
        host_op(1'b0, 8'h22, 16'h0, rd, lat);
        chk("host_rd_22", 32'(rd), 32'h1234);
        last_rd = rd;

        h_req = 1'b1; h_we = 1'b1; h_addr = 8'h40; h_wdata = 16'hA5A5;
        tick();
        tick();
        state = 1'b1; d_we = 1'b1; d_addr = 8'h40; d_dataout = 16'hFFFF;
        chk("access_no_ack", 32'(h_ack), 32'd0);
        tick();
        chk("access_exec_ack", 32'(h_ack), 32'd1);
        h_req = 1'b0; d_we = 1'b0; state = 1'b0;
        #1;
        chk("host_wins_access", 32'(d_datain), 32'hA5A5);
        model[8'h40] = 16'hA5A5;
        tick();
        chk("h_rdata_hold_wr", 32'(h_rdata), 32'(last_rd));

        for (int it = 0; it < 150; it++) begin
            a = 8'($urandom);
            dt = 16'($urandom);
            case ($urandom_range(0, 4))
                0: begin
                    state = 1'b1; d_we = 1'b1; d_addr = a; d_dataout = dt;
                    #1;
                    chk("rnd_cpu_old", 32'(d_datain), 32'(model[a]));
                    tick();
                    model[a] = dt;
                    d_we = 1'b0; state = 1'b0;
                    #1;
                    chk("rnd_cpu_new", 32'(d_datain), 32'(model[a]));
                end
                1: begin
                    d_we = 1'b1; d_addr = a; d_dataout = dt;
                    tick();
                    d_we = 1'b0;
                    #1;
                    chk("rnd_idle_wr", 32'(d_datain), 32'(model[a]));
                end
                2: begin
                    host_op(1'b1, a, dt, rd, lat);
                    model[a] = dt;
                    chk("rnd_hwr_lat", 32'(lat), 32'd3);
                    chk("rnd_hrdata_hold", 32'(h_rdata), 32'(last_rd));
                end
                3: begin
                    host_op(1'b0, a, 16'h0, rd, lat);
                    chk("rnd_hrd", 32'(rd), 32'(model[a]));
                    last_rd = rd;
                end
                default: begin
                    d_addr = a;
                    #1;
                    chk("rnd_cpu_rd", 32'(d_datain), 32'(model[a]));
                end
            endcase
        end

        h_req = 1'b1; h_we = 1'b1; h_addr = 8'h30; h_wdata = 16'h7777;
        tick();
        tick();
        reset = 1'b1; h_req = 1'b0;
        tick();
        chk("abort_no_ack", 32'(h_ack), 32'd0);
        chk("abort_init_done", 32'(init_done), 32'd0);
        chk("abort_h_rdata", 32'(h_rdata), 32'd0);
        reset = 1'b0;
        sweep_wait(n, ack_seen);
        chk("resweep_cycles", 32'(n), 32'd256);
        chk("resweep_no_ack", 32'(ack_seen), 32'd0);
        for (int i = 0; i < 256; i++) model[i] = '0;
        host_op(1'b0, 8'h30, 16'h0, rd, lat);
        chk("abort_rd_30", 32'(rd), 32'h0000);
        for (int i = 0; i < 8; i++) begin
            d_addr = 8'($urandom);
            #1;
            chk("resweep_cpu_rd", 32'(d_datain), 32'(model[d_addr]));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
